mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer that computes one signed dot product of length len on the 14x14->28-bit pipelined MAC (3-cycle latency, saturating accumulator).
- Reads operand pairs from two external synchronous memories (X activations, W weights) and streams them into the MAC.
- Counts MAC results, then captures and presents the final accumulation through a valid/ready result port.
- Sits between the convolution window scheduler (start/len side) and one MAC instance.

Parameters:
MAX_LEN, 64, maximum vector length per job
ADDR_W, 6, memory address width; clog2(MAX_LEN)
CNT_W, 7, width of len and internal counters; clog2(MAX_LEN+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset; all state cleared while low
start  in  1  job request, sampled in IDLE only
len  in  CNT_W  element count, sampled with start; legal range 1..MAX_LEN
busy  out  1  high from the cycle after start is accepted until result handshake completes
len_err  out  1  one-cycle pulse when start is sampled with len==0 or len>MAX_LEN
hold  in  1  high = issue no new memory reads; in-flight data still completes
mem_rd_en  out  1  read strobe to both memories
x_addr  out  ADDR_W  X memory address
w_addr  out  ADDR_W  W memory address; always equal to x_addr
x_data  in  14  signed X data, valid the cycle after mem_rd_en
w_data  in  14  signed W data, valid the cycle after mem_rd_en
mac_reset  out  1  synchronous active-high clear of the MAC
mac_a  out  14  MAC operand a
mac_b  out  14  MAC operand b
mac_valid_in  out  1  MAC valid_in
mac_f  in  28  MAC accumulator output f
mac_valid_out  in  1  MAC valid_out
result  out  28  signed dot product; held stable while result_valid is high
result_valid  out  1  result available
result_ready  in  1  consumer accepts result

Behaviour:
- Reset values: busy=0, len_err=0, mem_rd_en=0, x_addr=w_addr=0, mac_reset=1, mac_a=mac_b=0, mac_valid_in=0, result=0, result_valid=0; state=IDLE.
- Asserting reset mid-job aborts the job. The MAC is cleared on the first clock edge after release because mac_reset resets to 1.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: mac_reset=0. start with legal len latches len and moves to CLEAR. start with illegal len pulses len_err and stays in IDLE.
- CLEAR: exactly 1 cycle with mac_reset=1; issue counter and result counter cleared; moves to RUN.
- RUN: each cycle with hold=0, drive mem_rd_en=1 and address=issue count, then increment the issue count. When hold=1, mem_rd_en=0. After the len-th read is issued, move to DRAIN.
- Data path: mac_valid_in is mem_rd_en delayed one register stage. mac_a/mac_b = x_data/w_data passed combinationally, gated to 0 when mac_valid_in=0.
- Result counting: count mac_valid_out pulses in RUN and DRAIN. When the count reaches len, register mac_f into result, set result_valid=1 and move to DONE.
- DONE: result_valid held until result_ready=1 at a clock edge. On that edge, clear result_valid and busy and return to IDLE. result_ready outside DONE is ignored.
- Latency with hold never asserted: start accepted at edge E, result_valid rises after edge E+len+5.
- Throughput: one element per cycle. No back-to-back job overlap; the next start is accepted in IDLE, one cycle after the handshake at the earliest.
- start while busy: ignored, no len_err.
- Arithmetic: no extension or truncation in the controller. Saturation is performed by the MAC and passed through unchanged.
- hold during DRAIN or DONE has no effect.

Decomposition:
- Package mac_seq_pkg: state enum (IDLE, CLEAR, RUN, DRAIN, DONE), DATA_W=14, ACC_W=28, MAC_LAT=3.
- One natural sub-module, mac_issue_cnt: loadable up-counter with enable and terminal-count flag, instantiated twice (read issue, result count).
- Top-level test wrapper mac_seq_top: instantiates mac_seq_ctrl, part4_mac and two behavioural memories.

Test Plan:
- Basic: len=4, X={1,2,3,4}, W={5,6,7,8}, no hold -> result=70, result_valid rises 9 cycles after start, 4 mac_valid_in pulses, one mac_reset pulse.
- Backpressure and hold: len=3, X={-2,3,-4}, W={100,100,100}, hold high for 2 cycles after the first read, result_ready held low 5 cycles -> result=-300 stable throughout, busy high until handshake.
- Saturation: len=2, X={-8192,-8192}, W={-8192,-8192} -> result=28'h7FFFFFF.
- Boundaries: start with len=0 -> len_err pulse, busy stays 0; len=MAX_LEN with all ones -> result=64, last address=63; start during RUN -> ignored.
- Reset mid-job: assert reset in RUN of len=8 -> outputs return to reset values immediately. Follow-up job len=2, X={1,1}, W={3,3} -> result=6, no residue from the aborted job.

Source files
------------

// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_pkg
// Description : Shared types and widths for the MAC dot-product sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    localparam int DATA_W  = 14;   // operand width of the MAC
    localparam int ACC_W   = 28;   // accumulator width of the MAC
    localparam int MAC_LAT = 3;    // register stages from valid_in to valid_out

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_issue_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mac_issue_cnt
// Description : Clearable up-counter with enable and terminal-count flag.
//               tc is high while count equals the programmed last value.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_issue_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    // Count register: clear has priority over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == last);

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl
// Description : Sequencer for one signed dot product on a pipelined MAC.
//               Streams X/W operand pairs from synchronous memories into the
//               MAC, counts results and presents the final accumulation on a
//               valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int ADDR_W  = 6,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    output logic              len_err,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] w_data,
    output logic              mac_reset,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid_in,
    input  logic [ACC_W-1:0]  mac_f,
    input  logic              mac_valid_out,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    len_q;
    logic                len_ok;
    logic                clr_cnt;
    logic                issue_en;
    logic                issue_tc;
    logic [ADDR_W-1:0]   issue_cnt;
    logic                res_en;
    logic                res_tc;
    logic [CNT_W-1:0]    res_cnt;
    logic                capture;

    assign len_ok = (len != '0) && (len <= CNT_W'(MAX_LEN));

    // Read-issue counter doubles as the memory address
    mac_issue_cnt #(.W(ADDR_W)) u_issue_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .en    (issue_en),
        .last  (ADDR_W'(len_q - CNT_W'(1))),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    // Result counter tracks MAC valid_out pulses of the current job
    mac_issue_cnt #(.W(CNT_W)) u_res_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .en    (res_en),
        .last  (len_q - CNT_W'(1)),
        .count (res_cnt),
        .tc    (res_tc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        issue_en   = 1'b0;
        res_en     = 1'b0;
        clr_cnt    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start && len_ok) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_cnt    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                // guard keeps a stray pulse from overrunning the job length
                res_en = mac_valid_out && (res_cnt < len_q);
                if (!hold) begin
                    mem_rd_en = 1'b1;
                    issue_en  = 1'b1;
                    if (issue_tc) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                res_en = mac_valid_out && (res_cnt < len_q);
                if (mac_valid_out && res_tc) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs: MAC clear, operand valid, length latch, result port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_reset    <= 1'b1;
            mac_valid_in <= 1'b0;
            len_err      <= 1'b0;
            len_q        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            mac_reset    <= (state_next == CLEAR);
            mac_valid_in <= mem_rd_en;
            len_err      <= (state == IDLE) && start && !len_ok;
            if ((state == IDLE) && start && len_ok) begin
                len_q <= len;
            end
            if (capture) begin
                result       <= mac_f;
                result_valid <= 1'b1;
            end else if ((state == DONE) && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign x_addr = issue_cnt;
    assign w_addr = issue_cnt;

    // Memory data lines up with mac_valid_in; zero operands outside valid
    assign mac_a = mac_valid_in ? x_data : '0;
    assign mac_b = mac_valid_in ? w_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq_ctrl
// Description : Self-checking bench for mac_seq_ctrl with behavioural
//               memories and a saturating 3-stage MAC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

    localparam longint SAT_MAX = 134217727;
    localparam longint SAT_MIN = -134217728;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [6:0]         len;
    logic               busy;
    logic               len_err;
    logic               hold;
    logic               mem_rd_en;
    logic [5:0]         x_addr;
    logic [5:0]         w_addr;
    logic [13:0]        x_data;
    logic [13:0]        w_data;
    logic               mac_reset;
    logic [13:0]        mac_a;
    logic [13:0]        mac_b;
    logic               mac_valid_in;
    logic [27:0]        mac_f;
    logic               mac_valid_out;
    logic [27:0]        result;
    logic               result_valid;
    logic               result_ready;

    int                 chk_cnt  = 0;
    int                 pass_cnt = 0;
    int                 cyc      = 0;
    longint             sb[$];

    logic signed [13:0] xm [64];
    logic signed [13:0] wm [64];

    mac_seq_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .len_err       (len_err),
        .hold          (hold),
        .mem_rd_en     (mem_rd_en),
        .x_addr        (x_addr),
        .w_addr        (w_addr),
        .x_data        (x_data),
        .w_data        (w_data),
        .mac_reset     (mac_reset),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .result        (result),
        .result_valid  (result_valid),
        .result_ready  (result_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat28(input longint v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    // Synchronous-read memories
    always @(posedge clk) begin
        if (mem_rd_en) begin
            x_data <= xm[x_addr];
            w_data <= wm[w_addr];
        end
    end

    // MAC model: operand stage, product stage, saturating accumulate stage
    logic signed [13:0] s1_a, s1_b;
    logic               s1_v, s2_v, acc_v;
    logic signed [27:0] s2_p, acc;

    always @(posedge clk) begin
        if (mac_reset) begin
            s1_a <= '0; s1_b <= '0; s1_v <= 1'b0;
            s2_p <= '0; s2_v <= 1'b0;
            acc  <= '0; acc_v <= 1'b0;
        end else begin
            s1_a  <= mac_a;
            s1_b  <= mac_b;
            s1_v  <= mac_valid_in;
            s2_p  <= s1_a * s1_b;
            s2_v  <= s1_v;
            if (s2_v) acc <= 28'(sat28(longint'(acc) + longint'(s2_p)));
            acc_v <= s2_v;
        end
    end

    assign mac_f         = acc;
    assign mac_valid_out = acc_v;

    function automatic longint exp_dot(input int n);
        longint a = 0;
        for (int i = 0; i < n; i++) a = sat28(a + longint'(xm[i]) * longint'(wm[i]));
        return a;
    endfunction

    task automatic check_eq(input string tag, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // One complete job: start, optional hold after first read, optional
    // start pulse while running, result backpressure, then handshake.
    task automatic do_job(input int n, input int hold_len, input int ready_wait, input bit run_start);
        int     rd = 0, vi = 0, mr = 0, used = 0, last_a = -1, lat = -1, k = 0, a0;
        bit     seen = 0;
        longint exp_v;
        @(negedge clk);
        start = 1'b1;
        len   = 7'(n);
        @(posedge clk);
        #1;
        a0    = cyc;
        start = 1'b0;
        sb.push_back(exp_dot(n));
        check_eq("busy_after_start", busy, 1);
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            hold = (rd >= 1) && (used < hold_len);
            if (hold) used++;
            if (run_start) begin
                start = (k == 3);
                len   = 7'd5;
            end
            #1;
            if (run_start && k == 4) check_eq("start_in_run_no_err", len_err, 0);
            if (mem_rd_en) begin
                rd++;
                last_a = x_addr;
                if (x_addr != w_addr) check_eq("addr_equal", w_addr, x_addr);
            end
            if (!mac_valid_in && (mac_a != 0 || mac_b != 0)) check_eq("operand_gate", mac_a, 0);
            if (mac_valid_in) vi++;
            if (mac_reset) mr++;
            if (result_valid) begin
                seen = 1;
                lat  = cyc - a0;
            end
        end
        hold  = 1'b0;
        start = 1'b0;
        if (!seen) check_eq("result_timeout", 0, 1);
        check_eq("latency", lat, n + 5 + hold_len);
        check_eq("read_count", rd, n);
        check_eq("valid_in_count", vi, n);
        check_eq("mac_reset_pulses", mr, 1);
        check_eq("last_addr", last_a, n - 1);
        exp_v = sb.pop_front();
        check_eq("result", $signed(result), exp_v);
        for (int i = 0; i < ready_wait; i++) begin
            @(negedge clk);
            #1;
            check_eq("result_held", $signed(result), exp_v);
            check_eq("valid_held", result_valid, 1);
            check_eq("busy_held", busy, 1);
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check_eq("valid_cleared", result_valid, 0);
        check_eq("busy_cleared", busy, 0);
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        len          = '0;
        hold         = 1'b0;
        result_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            xm[i] = '0;
            wm[i] = '0;
        end
        #22;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_len_err", len_err, 0);
        check_eq("rst_mem_rd_en", mem_rd_en, 0);
        check_eq("rst_x_addr", x_addr, 0);
        check_eq("rst_w_addr", w_addr, 0);
        check_eq("rst_mac_reset", mac_reset, 1);
        check_eq("rst_mac_a", mac_a, 0);
        check_eq("rst_mac_b", mac_b, 0);
        check_eq("rst_mac_valid_in", mac_valid_in, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_result_valid", result_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Illegal lengths: zero and one past the maximum
        foreach (sb[i]) sb.delete(i);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1'b1;
            len   = (t == 0) ? 7'd0 : 7'd65;
            @(posedge clk);
            #1;
            start = 1'b0;
            check_eq("len_err_pulse", len_err, 1);
            check_eq("len_err_busy", busy, 0);
            @(posedge clk);
            #1;
            check_eq("len_err_one_cycle", len_err, 0);
            check_eq("len_err_still_idle", busy, 0);
        end

        // Basic dot product
        for (int i = 0; i < 4; i++) begin
            xm[i] = 14'(i + 1);
            wm[i] = 14'(i + 5);
        end
        check_eq("model_basic", exp_dot(4), 70);
        do_job(4, 0, 0, 0);

        // Hold after first read, result backpressure
        xm[0] = -14'sd2; xm[1] = 14'sd3; xm[2] = -14'sd4;
        wm[0] = 14'sd100; wm[1] = 14'sd100; wm[2] = 14'sd100;
        do_job(3, 2, 5, 0);

        // Positive saturation
        xm[0] = -14'sd8192; xm[1] = -14'sd8192;
        wm[0] = -14'sd8192; wm[1] = -14'sd8192;
        check_eq("model_sat", exp_dot(2), SAT_MAX);
        do_job(2, 0, 0, 0);

        // Maximum length with a start pulse while running
        for (int i = 0; i < 64; i++) begin
            xm[i] = 14'sd1;
            wm[i] = 14'sd1;
        end
        do_job(64, 0, 1, 1);

        // Abort a len=8 job in RUN, then a clean follow-up job
        @(negedge clk);
        start = 1'b1;
        len   = 7'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_mem_rd_en", mem_rd_en, 0);
        check_eq("abort_x_addr", x_addr, 0);
        check_eq("abort_mac_reset", mac_reset, 1);
        check_eq("abort_mac_valid_in", mac_valid_in, 0);
        check_eq("abort_mac_a", mac_a, 0);
        check_eq("abort_result_valid", result_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xm[0] = 14'sd1; xm[1] = 14'sd1;
        wm[0] = 14'sd3; wm[1] = 14'sd3;
        do_job(2, 0, 0, 0);
        check_eq("followup_expected", $signed(result), 6);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
